// File: rtl/router_ctrl_fsm_np.sv
`default_nettype none
// ============================================================================
//  Module   : router_ctrl_fsm_np
//  Brief    : Packet-router controller with registered destination, scoped
//             soft reset, bad-address drop and wait-till-empty timeout.
//  Revision : 1.0
// ============================================================================
module router_ctrl_fsm_np #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_int_reg,
    output logic                 drop_state,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_DECODE = 4'd0,
        ST_LFD    = 4'd1,
        ST_LD     = 4'd2,
        ST_FULL   = 4'd3,
        ST_LAF    = 4'd4,
        ST_LP     = 4'd5,
        ST_CPE    = 4'd6,
        ST_WAIT   = 4'd7,
        ST_DROP   = 4'd8
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NUM_PORTS-1:0]   r_dest;
    logic [NUM_PORTS-1:0]   w_next_dest;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   r_timeout_err;
    logic                   w_tmo;
    logic [NUM_PORTS-1:0]   w_onehot;
    logic                   w_addr_ok;
    logic                   w_addr_empty;
    logic                   w_dest_empty;
    logic                   w_srst_hit;

    // One-hot decode of the header address; out-of-range addresses decode to zero.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
        assign w_onehot[i] = (32'(data_in) == i);
    end

    assign w_addr_ok    = |w_onehot;
    assign w_addr_empty = |(fifo_empty & w_onehot);
    assign w_dest_empty = |(fifo_empty & r_dest);
    assign w_srst_hit   = |(soft_reset & r_dest);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_DECODE;
            r_dest        <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_dest        <= w_next_dest;
            r_cnt         <= w_next_cnt;
            r_timeout_err <= w_tmo;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_dest  = r_dest;
        w_tmo        = 1'b0;
        case (r_state)
            ST_DECODE: begin
                if (pkt_valid) begin
                    if (!w_addr_ok) begin
                        w_next_state = ST_DROP;
                    end else begin
                        w_next_dest  = w_onehot;
                        w_next_state = w_addr_empty ? ST_LFD : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Empty takes priority over an expiring timeout in the same cycle.
                if (w_dest_empty) begin
                    w_next_state = ST_LFD;
                end else if ((TIMEOUT != 0) && (r_cnt == c_TMO_LAST)) begin
                    w_next_state = ST_DROP;
                    w_tmo        = 1'b1;
                end
            end
            ST_LFD:  w_next_state = ST_LD;
            ST_LD: begin
                if (fifo_full)       w_next_state = ST_FULL;
                else if (!pkt_valid) w_next_state = ST_LP;
            end
            ST_FULL: begin
                if (!fifo_full) w_next_state = ST_LAF;
            end
            ST_LAF: begin
                if (parity_done)        w_next_state = ST_DECODE;
                else if (low_pkt_valid) w_next_state = ST_LP;
                else                    w_next_state = ST_LD;
            end
            ST_LP:   w_next_state = ST_CPE;
            ST_CPE:  w_next_state = fifo_full ? ST_FULL : ST_DECODE;
            ST_DROP: begin
                if (!pkt_valid) w_next_state = ST_DECODE;
            end
            default: w_next_state = ST_DECODE;
        endcase

        if (w_srst_hit) begin
            w_next_state = ST_DECODE;
            w_tmo        = 1'b0;
        end
        if (w_next_state == ST_DECODE) begin
            w_next_dest = '0;
        end
    end

    assign w_next_cnt = ((r_state == ST_WAIT) && (w_next_state == ST_WAIT))
                      ? r_cnt + CNT_W'(1) : '0;

    assign dest_sel      = r_dest;
    assign detect_add    = (r_state == ST_DECODE);
    assign lfd_state     = (r_state == ST_LFD);
    assign ld_state      = (r_state == ST_LD);
    assign full_state    = (r_state == ST_FULL);
    assign laf_state     = (r_state == ST_LAF);
    assign rst_int_reg   = (r_state == ST_CPE);
    assign drop_state    = (r_state == ST_DROP);
    assign write_enb_reg = (r_state == ST_LD) || (r_state == ST_LP) || (r_state == ST_LAF);
    assign busy          = !((r_state == ST_DECODE) || (r_state == ST_LD) || (r_state == ST_DROP));
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl_fsm_np.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_ctrl_fsm_np
//  Brief    : Directed bench for router_ctrl_fsm_np (default and TIMEOUT=4).
//  Revision : 1.0
// ============================================================================
module tb_router_ctrl_fsm_np;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic [2:0] fifo_empty = 3'b111;
    logic       fifo_full = 1'b0;
    logic [2:0] soft_reset = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;

    logic [2:0] dest_sel, t_dest_sel;
    logic detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
    logic drop_state, write_enb_reg, busy, timeout_err;
    logic t_detect_add, t_lfd_state, t_ld_state, t_full_state, t_laf_state, t_rst_int_reg;
    logic t_drop_state, t_write_enb_reg, t_busy, t_timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;

    // {detect,lfd,ld,full,laf,cpe,drop, write_enb, busy, timeout_err}
    localparam logic [9:0] c_DA   = 10'b1000000_0_0_0;
    localparam logic [9:0] c_LFD  = 10'b0100000_0_1_0;
    localparam logic [9:0] c_LD   = 10'b0010000_1_0_0;
    localparam logic [9:0] c_FULL = 10'b0001000_0_1_0;
    localparam logic [9:0] c_LAF  = 10'b0000100_1_1_0;
    localparam logic [9:0] c_CPE  = 10'b0000010_0_1_0;
    localparam logic [9:0] c_DROP = 10'b0000001_0_0_0;
    localparam logic [9:0] c_DTMO = 10'b0000001_0_0_1;
    localparam logic [9:0] c_LP   = 10'b0000000_1_1_0;
    localparam logic [9:0] c_WAIT = 10'b0000000_0_1_0;

    wire [9:0] flags   = {detect_add, lfd_state, ld_state, full_state, laf_state,
                          rst_int_reg, drop_state, write_enb_reg, busy, timeout_err};
    wire [9:0] t_flags = {t_detect_add, t_lfd_state, t_ld_state, t_full_state, t_laf_state,
                          t_rst_int_reg, t_drop_state, t_write_enb_reg, t_busy, t_timeout_err};

    router_ctrl_fsm_np dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .dest_sel(dest_sel), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .full_state(full_state), .laf_state(laf_state),
        .rst_int_reg(rst_int_reg), .drop_state(drop_state),
        .write_enb_reg(write_enb_reg), .busy(busy), .timeout_err(timeout_err)
    );

    router_ctrl_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .dest_sel(t_dest_sel), .detect_add(t_detect_add), .lfd_state(t_lfd_state),
        .ld_state(t_ld_state), .full_state(t_full_state), .laf_state(t_laf_state),
        .rst_int_reg(t_rst_int_reg), .drop_state(t_drop_state),
        .write_enb_reg(t_write_enb_reg), .busy(t_busy), .timeout_err(t_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset_flags", 32'(flags), 32'(c_DA));
        chk("reset_dest", 32'(dest_sel), 32'd0);
        tick();
        reset = 1'b1;

        // Packet to empty port 1, three payload bytes
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(); chk("p1_lfd", 32'(flags), 32'(c_LFD));
        chk("p1_dest", 32'(dest_sel), 32'b010);
        tick(); chk("p1_ld1", 32'(flags), 32'(c_LD)); we_cnt += int'(write_enb_reg);
        tick(); chk("p1_ld2", 32'(flags), 32'(c_LD)); we_cnt += int'(write_enb_reg);
        tick(); chk("p1_ld3", 32'(flags), 32'(c_LD)); we_cnt += int'(write_enb_reg);
        pkt_valid = 1'b0;
        tick(); chk("p1_lp", 32'(flags), 32'(c_LP)); we_cnt += int'(write_enb_reg);
        tick(); chk("p1_cpe", 32'(flags), 32'(c_CPE)); we_cnt += int'(write_enb_reg);
        tick(); chk("p1_da", 32'(flags), 32'(c_DA)); we_cnt += int'(write_enb_reg);
        chk("p1_dest_clr", 32'(dest_sel), 32'd0);
        chk("p1_we_cycles", 32'(we_cnt), 32'd4);

        // Port 2 busy for five cycles, then empties (default TIMEOUT)
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
        tick();
        chk("w_dest", 32'(dest_sel), 32'b100);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w_wait%0d", i), 32'(flags), 32'(c_WAIT));
            if (i == 4) fifo_empty = 3'b111;
            tick();
        end
        chk("w_lfd", 32'(flags), 32'(c_LFD));
        pkt_valid = 1'b0;
        tick(); chk("w_ld", 32'(flags), 32'(c_LD));
        tick(); tick(); tick();
        chk("w_done", 32'(flags), 32'(c_DA));

        // TIMEOUT=4 instance: port 0 never empties
        do_reset();
        fifo_empty = 3'b110; pkt_valid = 1'b1; data_in = 2'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t_wait%0d", i), 32'(t_flags), 32'(c_WAIT));
            tick();
        end
        chk("t_drop_err", 32'(t_flags), 32'(c_DTMO));
        tick(); chk("t_drop_pulse_end", 32'(t_flags), 32'(c_DROP));
        pkt_valid = 1'b0;
        tick(); chk("t_back_da", 32'(t_flags), 32'(c_DA));

        // Non-existent port 3
        do_reset();
        fifo_empty = 3'b111; pkt_valid = 1'b1; data_in = 2'd3;
        tick(); chk("bad_drop", 32'(flags), 32'(c_DROP));
        chk("bad_dest", 32'(dest_sel), 32'd0);
        tick(); chk("bad_drop2", 32'(flags), 32'(c_DROP));
        pkt_valid = 1'b0;
        tick(); chk("bad_da", 32'(flags), 32'(c_DA));

        // FIFO full during LOAD_DATA for three cycles, then low_pkt_valid
        data_in = 2'd0; pkt_valid = 1'b1;
        tick(); tick();
        chk("f_ld", 32'(flags), 32'(c_LD));
        fifo_full = 1'b1;
        tick(); chk("f_full1", 32'(flags), 32'(c_FULL));
        tick(); chk("f_full2", 32'(flags), 32'(c_FULL));
        tick(); chk("f_full3", 32'(flags), 32'(c_FULL));
        fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        tick(); chk("f_laf", 32'(flags), 32'(c_LAF));
        tick(); chk("f_lp", 32'(flags), 32'(c_LP));
        low_pkt_valid = 1'b0;
        tick(); chk("f_cpe", 32'(flags), 32'(c_CPE));
        tick(); chk("f_da", 32'(flags), 32'(c_DA));

        // Soft reset scoped to the active destination
        data_in = 2'd0; pkt_valid = 1'b1;
        tick(); tick();
        chk("s_dest", 32'(dest_sel), 32'b001);
        soft_reset = 3'b100;
        tick(); chk("s_other_ignored", 32'(flags), 32'(c_LD));
        soft_reset = 3'b001;
        tick(); chk("s_hit_da", 32'(flags), 32'(c_DA));
        chk("s_hit_dest", 32'(dest_sel), 32'd0);
        soft_reset = 3'b000;

        // Async reset in the middle of LOAD_DATA
        tick(); tick();
        chk("a_ld", 32'(flags), 32'(c_LD));
        #2 reset = 1'b0;
        #1;
        chk("a_flags", 32'(flags), 32'(c_DA));
        chk("a_dest", 32'(dest_sel), 32'd0);
        reset = 1'b1;
        pkt_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/router_ctrl_fsm_np.md
Name: router_ctrl_fsm_np

Overview:
- Parametrised next-generation packet-router controller. Decodes a header address, selects one of NUM_PORTS destination FIFOs, and sequences header, payload and parity loading. It handles FIFO-full stalls and parity checking.
- Adds four things the current controller lacks:
  - registered destination capture;
  - per-port soft reset scoped to the active destination;
  - drop of packets addressed to a non-existent port;
  - programmable wait-till-empty timeout with an error pulse.
- Sits between the router input register block and the per-port FIFOs/synchroniser.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs (1..2**ADDR_W).
- ADDR_W, 2, width of the header address field (data_in[ADDR_W-1:0]).
- TIMEOUT, 30, max cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- pkt_valid  in  1  packet valid from source.
- data_in  in  ADDR_W  header address bits (valid in DECODE_ADDRESS).
- fifo_empty  in  NUM_PORTS  per-port FIFO empty.
- fifo_full  in  1  full flag of the currently selected FIFO (muxed externally).
- soft_reset  in  NUM_PORTS  per-port soft reset from the synchroniser.
- parity_done  in  1  parity byte latched by the register block.
- low_pkt_valid  in  1  packet ended while in full state.
- dest_sel  out  NUM_PORTS  one-hot registered destination; 0 when none.
- detect_add  out  1  state==DECODE_ADDRESS.
- lfd_state  out  1  state==LOAD_FIRST_DATA.
- ld_state  out  1  state==LOAD_DATA.
- full_state  out  1  state==FIFO_FULL_STATE.
- laf_state  out  1  state==LOAD_AFTER_FULL.
- rst_int_reg  out  1  state==CHECK_PARITY_ERROR.
- drop_state  out  1  state==DROP_PACKET.
- write_enb_reg  out  1  state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}.
- busy  out  1  low only in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET.
- timeout_err  out  1  registered one-cycle pulse on wait timeout.

Behaviour:
- Reset (async, active-low):
  - state=DECODE_ADDRESS, dest reg=0, wait counter=0, timeout_err=0.
  - Resulting outputs: detect_add=1, busy=0, all other outputs 0.
- State/output decode: all state outputs are Moore decodes of the state register. dest_sel is driven from the registered one-hot destination.
- DECODE_ADDRESS (no pkt_valid): stays in DECODE_ADDRESS.
- DECODE_ADDRESS with pkt_valid, address a=data_in:
  - a>=NUM_PORTS: -> DROP_PACKET, dest=0.
  - fifo_empty[a]=1: -> LOAD_FIRST_DATA.
  - fifo_empty[a]=0: -> WAIT_TILL_EMPTY.
  - In both valid-address cases dest<=onehot(a) on the same edge.
- WAIT_TILL_EMPTY:
  - Counter increments each cycle.
  - If fifo_empty[dest] is set: -> LOAD_FIRST_DATA; empty wins over timeout in the same cycle.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: -> DROP_PACKET, timeout_err=1 for one cycle.
  - Counter clears on exit.
- LOAD_FIRST_DATA: -> LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full: -> FIFO_FULL_STATE.
  - else if !pkt_valid: -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done: -> DECODE_ADDRESS.
  - else low_pkt_valid: -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- DROP_PACKET: busy=0 so the source streams; nothing is written. pkt_valid low -> DECODE_ADDRESS.
- Destination lifetime: dest holds until the next accepted header. It clears to 0 on returning to DECODE_ADDRESS.
- Soft reset: synchronous; soft_reset bits are ANDed with dest. Any resulting hit forces state=DECODE_ADDRESS and dest=0 next edge, overriding all transitions. Soft resets for non-selected ports are ignored.
- Unused state encodings: -> DECODE_ADDRESS.
- Mid-packet async reset: returns immediately to the reset values; no partial-state outputs remain asserted.

Test Plan:
- Port 1 empty, header data_in=1, 3 payload bytes, pkt_valid drops:
  - dest_sel=3'b010.
  - State sequence DECODE->LFD->LD x3->LP->CPE->DECODE; write_enb_reg high 4 cycles.
- Header to port 2 with fifo_empty=3'b011, empty asserts after 5 cycles:
  - busy=1 in WAIT for 5 cycles, then LFD.
  - timeout_err stays 0.
- TIMEOUT=4, port 0 never empties:
  - WAIT for exactly 4 cycles, then DROP_PACKET with a single timeout_err pulse.
  - busy=0 in DROP; return to DECODE when pkt_valid falls.
- data_in=3 with NUM_PORTS=3:
  - Immediate DROP_PACKET; write_enb_reg never asserted; dest_sel=0.
- fifo_full in LOAD_DATA, released after 3 cycles, low_pkt_valid=1:
  - FULL x3 -> LAF -> LP -> CPE.
- soft_reset=3'b100 while routing to port 0 does not change state. soft_reset=3'b001 in that case forces DECODE next edge. Reset asserted mid-LD returns outputs to reset values asynchronously.
